// File: rtl/mod_n_pkg.sv
// Shared types and constants for the modulo-N counter sequencer.
package mod_n_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MOD_MIN = 2;

endpackage

// File: rtl/mod_n_core.sv
// Modulo-N counting datapath: counts while en, wraps at mod-1 and flags the wrap cycle.
module mod_n_core #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] mod,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic at_top;

    assign at_top = (q == W'(mod - W'(1)));
    assign wrap   = en && at_top && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= at_top ? '0 : W'(q + W'(1));
        end
    end

endmodule

// File: rtl/mod_n_ctrl.sv
// Sequencer running a modulo-N counter for a configured number of periods.
// Optional MOD_N_CTRL_PAUSE_EN adds a pause input that freezes the run.
module mod_n_ctrl
    import mod_n_pkg::*;
#(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_mod,
    input  logic [CW-1:0] cfg_periods,
    input  logic          abort,
`ifdef MOD_N_CTRL_PAUSE_EN
    input  logic          pause,
`endif
    output logic          busy,
    output logic [W-1:0]  q,
    output logic          tc,
    output logic          done,
    output logic          err
);

    state_t        state, state_nx;
    logic [W-1:0]  mod_r;
    logic [CW-1:0] per_r;
    logic [CW-1:0] pcnt;
    logic          pause_act;
    logic          cfg_ok;
    logic          accept;
    logic          reject;
    logic          last_wrap;
    logic          core_en;
    logic          core_clr;
    logic          wrap;

`ifdef MOD_N_CTRL_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    assign cfg_ok    = (cfg_mod >= W'(MOD_MIN)) && (cfg_periods != '0);
    // Compare before incrementing so the maximum period count never overflows.
    assign last_wrap = wrap && (pcnt == CW'(per_r - CW'(1)));

    mod_n_core #(.W(W)) u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (core_en),
        .clr  (core_clr),
        .mod  (mod_r),
        .q    (q),
        .wrap (wrap)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort wins over a simultaneous final wrap
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (cfg_valid && cfg_ok) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last_wrap) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath control and combinational terminal count
    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        core_en  = 1'b0;
        core_clr = 1'b0;
        tc       = 1'b0;
        case (state)
            IDLE: begin
                accept   = cfg_valid && cfg_ok;
                reject   = cfg_valid && !cfg_ok;
                core_clr = accept;
            end
            RUN: begin
                core_clr = abort;
                core_en  = !abort && !pause_act;
                tc       = !pause_act && (q == W'(mod_r - W'(1)));
            end
            default: begin
                core_en = 1'b0;
            end
        endcase
    end

    // Config latches and period counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_r <= '0;
            per_r <= '0;
            pcnt  <= '0;
        end else begin
            if (accept) begin
                mod_r <= cfg_mod;
                per_r <= cfg_periods;
                pcnt  <= '0;
            end else if (state == RUN) begin
                if (abort || last_wrap) begin
                    pcnt <= '0;
                end else if (wrap) begin
                    pcnt <= CW'(pcnt + CW'(1));
                end
            end
        end
    end

    // Registered status outputs track the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cfg_ready <= (state_nx == IDLE);
            busy      <= (state_nx == RUN);
            done      <= (state_nx == DONE);
            err       <= reject;
        end
    end

endmodule
